// File: rtl/cache_module_if.sv
// Controller-side operation bus of the L2 tag/state store.
// One operation per cycle in; registered lookup/MESI/victim results out.
interface cache_module_if #(
   parameter int INDEX_SIZE = 14,
   parameter int TAG_SIZE   = 12
);
   logic                  op_valid;
   logic [2:0]            op;
   logic [INDEX_SIZE-1:0] index;
   logic [TAG_SIZE-1:0]   tag;
   logic [2:0]            way;
   logic [3:0]            command;
   logic [1:0]            snoop_result;
   logic [3:0]            result;
   logic                  result_valid;
   logic [1:0]            mesi_out;
   logic [2:0]            victim_way;

   modport master (
      output op_valid, op, index, tag, way, command, snoop_result,
      input  result, result_valid, mesi_out, victim_way
   );

   modport slave (
      input  op_valid, op, index, tag, way, command, snoop_result,
      output result, result_valid, mesi_out, victim_way
   );
endinterface

// File: rtl/cache_module.sv
// L2 tag/state store: 8-way set-associative tags, per-line MESI and
// per-set 7-bit tree pseudo-LRU; one controller operation per cycle.
module cache_module #(
   parameter int INDEX_SIZE  = 14,
   parameter int TAG_SIZE    = 12,
   parameter int OFFSET_SIZE = 6,
   parameter int WAYS        = 8
) (
   input logic           clk,
   input logic           reset,
   cache_module_if.slave bus
);
   localparam int SETS = 1 << INDEX_SIZE;

   localparam logic [2:0] OP_LOOKUP = 3'd0;
   localparam logic [2:0] OP_WTAG   = 3'd1;
   localparam logic [2:0] OP_LRU    = 3'd2;
   localparam logic [2:0] OP_MESI   = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;

   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_S = 2'd1;
   localparam logic [1:0] ST_E = 2'd2;
   localparam logic [1:0] ST_M = 2'd3;

   if (WAYS != 8 || OFFSET_SIZE < 1) begin : g_cfg_err
      $error("cache_module: WAYS must be 8 and OFFSET_SIZE positive");
   end

   logic [TAG_SIZE-1:0] tag_q [SETS][8];
   logic [15:0]         mesi_set [SETS];
   logic [6:0]          plru_set [SETS];

   logic [3:0] result_q, result_d;
   logic       result_valid_q, result_valid_d;
   logic [1:0] mesi_out_q, mesi_out_d;
   logic [2:0] victim_q, victim_d;

   logic       tag_we_d, mesi_we_d, plru_we_d, clear_d;
   logic [1:0] mesi_new_d;
   logic [6:0] plru_new_d;

   logic [15:0] cur_set;
   logic [6:0]  cur_plru;
   logic [1:0]  cur_mesi;
   logic        hit, inv_any;
   logic [2:0]  hit_way, inv_way, lru_way;
   logic        lru_l1;

   function automatic logic [1:0] mesi_next(
      input logic [1:0] cur,
      input logic [3:0] cmd,
      input logic [1:0] snp
   );
      logic [1:0] nxt;
      nxt = cur;
      case (cmd)
         4'd0, 4'd2: if (cur == ST_I) nxt = (snp[1] ? ST_E : ST_S);
         4'd1:       nxt = ST_M;
         4'd3:       if (cur == ST_S) nxt = ST_I;
         4'd4:       if (cur == ST_E || cur == ST_M) nxt = ST_S;
         4'd6:       nxt = ST_I;
         default:    nxt = cur;
      endcase
      return nxt;
   endfunction

   // Set lookup: lowest matching valid way wins; lowest invalid way
   // is preferred over the PLRU choice for replacement.
   always_comb begin
      cur_set  = mesi_set[bus.index];
      cur_plru = plru_set[bus.index];
      cur_mesi = cur_set[{bus.way, 1'b0} +: 2];
      hit      = 1'b0;
      hit_way  = 3'd0;
      inv_any  = 1'b0;
      inv_way  = 3'd0;
      for (int w = 7; w >= 0; w--) begin
         if (cur_set[2*w +: 2] != ST_I &&
             tag_q[bus.index][w] == bus.tag) begin
            hit     = 1'b1;
            hit_way = 3'(w);
         end
         if (cur_set[2*w +: 2] == ST_I) begin
            inv_any = 1'b1;
            inv_way = 3'(w);
         end
      end
      lru_l1     = cur_plru[0] ? cur_plru[2] : cur_plru[1];
      lru_way[2] = cur_plru[0];
      lru_way[1] = lru_l1;
      lru_way[0] = cur_plru[3'd3 + {1'b0, cur_plru[0], lru_l1}];
   end

   always_comb begin
      result_d       = result_q;
      result_valid_d = 1'b0;
      mesi_out_d     = mesi_out_q;
      victim_d       = victim_q;
      tag_we_d       = 1'b0;
      mesi_we_d      = 1'b0;
      plru_we_d      = 1'b0;
      clear_d        = 1'b0;
      mesi_new_d     = mesi_next(cur_mesi, bus.command, bus.snoop_result);
      // Path bits point away from the touched way.
      plru_new_d     = cur_plru;
      plru_new_d[0]  = ~bus.way[2];
      if (bus.way[2]) plru_new_d[2] = ~bus.way[1];
      else            plru_new_d[1] = ~bus.way[1];
      plru_new_d[3'd3 + {1'b0, bus.way[2:1]}] = ~bus.way[0];
      if (bus.op_valid) begin
         case (bus.op)
            OP_LOOKUP: begin
               result_d       = hit ? {hit_way, 1'b1} : 4'b0000;
               result_valid_d = 1'b1;
               mesi_out_d     = hit ? cur_set[{hit_way, 1'b0} +: 2] : ST_I;
               victim_d       = inv_any ? inv_way : lru_way;
            end
            OP_WTAG: begin
               tag_we_d   = 1'b1;
               mesi_out_d = cur_mesi;
            end
            OP_LRU: begin
               plru_we_d  = 1'b1;
               mesi_out_d = cur_mesi;
            end
            OP_MESI: begin
               mesi_we_d  = 1'b1;
               mesi_out_d = mesi_new_d;
            end
            OP_CLEAR: begin
               clear_d    = 1'b1;
               mesi_out_d = ST_I;
            end
            default: ;
         endcase
      end
   end

   for (genvar s = 0; s < SETS; s++) begin : g_set
      logic [15:0] mesi_q;
      logic [6:0]  plru_q;
      logic        sel;
      assign sel = (bus.index == INDEX_SIZE'(s));
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mesi_q <= '0;
            plru_q <= '0;
         end else if (clear_d) begin
            mesi_q <= '0;
            plru_q <= '0;
         end else if (sel) begin
            if (mesi_we_d) mesi_q[{bus.way, 1'b0} +: 2] <= mesi_new_d;
            if (plru_we_d) plru_q <= plru_new_d;
         end
      end
      assign mesi_set[s] = mesi_q;
      assign plru_set[s] = plru_q;
   end

   // Tags are plain storage; a line is only meaningful while its MESI != I.
   always_ff @(posedge clk) begin
      if (tag_we_d && !reset) tag_q[bus.index][bus.way] <= bus.tag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q       <= '0;
         result_valid_q <= 1'b0;
         mesi_out_q     <= ST_I;
         victim_q       <= '0;
      end else begin
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         mesi_out_q     <= mesi_out_d;
         victim_q       <= victim_d;
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.mesi_out     = mesi_out_q;
   assign bus.victim_way   = victim_q;
endmodule

// File: tb/tb_cache_module.sv
// Bench for cache_module: directed scenarios plus random traffic
// against a behavioural set/way model with a heap-indexed PLRU tree.
module tb_cache_module;
   localparam int IDX  = 4;
   localparam int SETS = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_module_if #(.INDEX_SIZE(IDX), .TAG_SIZE(12)) bus ();

   cache_module #(
      .INDEX_SIZE(IDX), .TAG_SIZE(12), .OFFSET_SIZE(6), .WAYS(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic [11:0] tag_m  [SETS][8];
   int          mesi_m [SETS][8];
   bit          plru_m [SETS][7];

   logic [3:0] e_res;
   logic       e_rv;
   logic [1:0] e_mesi;
   logic [2:0] e_vic;

   task automatic chk(input string nm, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   // MESI: 0=I 1=S 2=E 3=M
   function automatic int m_next(input int cur, input int cmd,
                                 input int snp);
      case (cmd)
         0, 2:    return (cur == 0) ? ((snp < 2) ? 1 : 2) : cur;
         1:       return 3;
         3:       return (cur == 1) ? 0 : cur;
         4:       return (cur >= 2) ? 1 : cur;
         6:       return 0;
         default: return cur;
      endcase
   endfunction

   function automatic int m_victim(input int s);
      int node, v, b;
      for (int w = 0; w < 8; w++)
         if (mesi_m[s][w] == 0) return w;
      node = 0;
      v = 0;
      for (int l = 0; l < 3; l++) begin
         b = int'(plru_m[s][node]);
         v = v * 2 + b;
         node = 2 * node + 1 + b;
      end
      return v;
   endfunction

   task automatic m_touch(input int s, input int w);
      int node, b;
      node = 0;
      for (int l = 2; l >= 0; l--) begin
         b = (w >> l) & 1;
         plru_m[s][node] = (b == 0);
         node = 2 * node + 1 + b;
      end
   endtask

   task automatic m_clear();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < 8; w++) mesi_m[s][w] = 0;
         for (int n = 0; n < 7; n++) plru_m[s][n] = 1'b0;
      end
   endtask

   task automatic m_reset();
      m_clear();
      e_res  = 4'd0;
      e_rv   = 1'b0;
      e_mesi = 2'd0;
      e_vic  = 3'd0;
   endtask

   task automatic m_apply(input int op, input int s, input int t,
                          input int w, input int cmd, input int snp,
                          input bit vld);
      int hw;
      e_rv = 1'b0;
      if (!vld) return;
      case (op)
         0: begin
            hw = -1;
            for (int k = 0; k < 8; k++)
               if (hw < 0 && mesi_m[s][k] != 0 && tag_m[s][k] == 12'(t))
                  hw = k;
            e_rv   = 1'b1;
            e_res  = (hw >= 0) ? 4'(hw * 2 + 1) : 4'd0;
            e_mesi = (hw >= 0) ? 2'(mesi_m[s][hw]) : 2'd0;
            e_vic  = 3'(m_victim(s));
         end
         1: begin
            tag_m[s][w] = 12'(t);
            e_mesi = 2'(mesi_m[s][w]);
         end
         2: begin
            m_touch(s, w);
            e_mesi = 2'(mesi_m[s][w]);
         end
         3: begin
            mesi_m[s][w] = m_next(mesi_m[s][w], cmd, snp);
            e_mesi = 2'(mesi_m[s][w]);
         end
         4: begin
            m_clear();
            e_mesi = 2'd0;
         end
         default: ;
      endcase
   endtask

   task automatic do_op(input int op, input int s, input int t,
                        input int w, input int cmd, input int snp,
                        input bit vld);
      @(negedge clk);
      bus.op_valid     = vld;
      bus.op           = 3'(op);
      bus.index        = IDX'(s);
      bus.tag          = 12'(t);
      bus.way          = 3'(w);
      bus.command      = 4'(cmd);
      bus.snoop_result = 2'(snp);
      m_apply(op, s, t, w, cmd, snp, vld);
      @(posedge clk);
      #1;
      bus.op_valid = 1'b0;
      chk("result", 32'(bus.result), 32'(e_res));
      chk("result_valid", 32'(bus.result_valid), 32'(e_rv));
      chk("victim_way", 32'(bus.victim_way), 32'(e_vic));
      if (vld && op == 3) chk("mesi_out", 32'(bus.mesi_out), 32'(e_mesi));
   endtask

   task automatic lookup(input int s, input int t);
      do_op(0, s, t, 0, 0, 3, 1'b1);
   endtask
   task automatic wtag(input int s, input int t, input int w);
      do_op(1, s, t, w, 0, 3, 1'b1);
   endtask
   task automatic touch(input int s, input int w);
      do_op(2, s, 0, w, 0, 3, 1'b1);
   endtask
   task automatic upd_mesi(input int s, input int w, input int cmd,
                           input int snp);
      do_op(3, s, 0, w, cmd, snp, 1'b1);
   endtask

   initial begin
      int op, s, t, w, cmd, snp;
      bit vld;
      reset            = 1'b1;
      bus.op_valid     = 1'b0;
      bus.op           = '0;
      bus.index        = '0;
      bus.tag          = '0;
      bus.way          = '0;
      bus.command      = '0;
      bus.snoop_result = '0;
      m_reset();
      #12;
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_mesi", 32'(bus.mesi_out), 32'd0);
      chk("rst_victim", 32'(bus.victim_way), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      lookup(0, 'h111);
      chk("cold_miss", 32'(bus.result), 32'h0);
      chk("cold_victim", 32'(bus.victim_way), 32'd0);

      wtag(0, 'h111, 2);
      touch(0, 2);
      upd_mesi(0, 2, 1, 0);
      chk("fill_m", 32'(bus.mesi_out), 32'd3);
      lookup(0, 'h111);
      chk("hit_way2", 32'(bus.result), 32'h5);
      lookup(1, 'h111);
      chk("iso_set", 32'(bus.result), 32'h0);
      lookup(0, 'h222);
      chk("iso_tag", 32'(bus.result), 32'h0);

      wtag(3, 'h333, 1);
      upd_mesi(3, 1, 0, 2);
      chk("i_to_e", 32'(bus.mesi_out), 32'd2);
      upd_mesi(3, 1, 4, 3);
      chk("e_to_s", 32'(bus.mesi_out), 32'd1);
      upd_mesi(3, 1, 3, 3);
      chk("s_to_i", 32'(bus.mesi_out), 32'd0);
      lookup(3, 'h333);
      chk("inv_miss", 32'(bus.result), 32'h0);
      wtag(3, 'h334, 4);
      upd_mesi(3, 4, 0, 1);
      chk("hitm_to_s", 32'(bus.mesi_out), 32'd1);

      for (int k = 0; k < 8; k++) begin
         wtag(5, 'h500 + k, k);
         upd_mesi(5, k, 1, 0);
      end
      for (int k = 0; k < 8; k++) touch(5, k);
      lookup(5, 'h777);
      chk("plru_v0", 32'(bus.victim_way), 32'd0);
      touch(5, 0);
      lookup(5, 'h503);
      chk("plru_v4", 32'(bus.victim_way), 32'd4);
      chk("hit_way3", 32'(bus.result), 32'h7);

      @(negedge clk);
      bus.op_valid = 1'b1;
      bus.op       = 3'd3;
      bus.index    = IDX'(5);
      bus.way      = 3'd3;
      bus.command  = 4'd6;
      #2;
      reset = 1'b1;
      #1;
      m_reset();
      chk("arst_result", 32'(bus.result), 32'd0);
      chk("arst_victim", 32'(bus.victim_way), 32'd0);
      chk("arst_mesi", 32'(bus.mesi_out), 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold", 32'(bus.result_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.op_valid = 1'b0;
      lookup(5, 'h503);
      chk("arst_miss", 32'(bus.result), 32'h0);

      wtag(0, 'h111, 6);
      upd_mesi(0, 6, 1, 0);
      upd_mesi(5, 3, 0, 2);
      touch(5, 3);
      lookup(0, 'h111);
      chk("pre_clr_hit", 32'(bus.result), 32'hD);
      do_op(4, 0, 0, 0, 0, 3, 1'b1);
      lookup(0, 'h111);
      chk("clr_miss0", 32'(bus.result), 32'h0);
      lookup(5, 'h503);
      chk("clr_miss5", 32'(bus.result), 32'h0);
      chk("clr_victim", 32'(bus.victim_way), 32'd0);

      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++) wtag(k, $urandom_range(0, 3), j);
      for (int n = 0; n < 500; n++) begin
         op  = $urandom_range(0, 6);
         if (op == 4 && $urandom_range(0, 7) != 0) op = 0;
         s   = $urandom_range(0, 7);
         t   = $urandom_range(0, 3);
         w   = $urandom_range(0, 7);
         cmd = $urandom_range(0, 7);
         snp = $urandom_range(0, 3);
         vld = ($urandom_range(0, 9) != 0);
         do_op(op, s, t, w, cmd, snp, vld);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cache_module.md
Name: cache_module

Overview:
- Tag/state store of the split L2 cache: 8-way set-associative.
- Per-line storage: tag plus 2-bit MESI state.
- Per-set storage: 7-bit tree pseudo-LRU.
- One operation per cycle from the cache controller: lookup, tag write, LRU update, MESI update or clear. Data array and bus interface sit outside this block.

Parameters:
INDEX_SIZE, 14, set index width (2^INDEX_SIZE sets)
TAG_SIZE, 12, tag width
OFFSET_SIZE, 6, line offset width (not stored; carried for address split)
WAYS, 8, associativity (fixed; way field 3 bits)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
op_valid  in  1  operation strobe, one op per cycle
op  in  3  0=LOOKUP, 1=WRITE_TAG, 2=UPDATE_LRU, 3=UPDATE_MESI, 4=CLEAR; others = no-op
index  in  INDEX_SIZE  set index
tag  in  TAG_SIZE  tag
way  in  3  target way for WRITE_TAG/UPDATE_LRU/UPDATE_MESI
command  in  4  trace command for UPDATE_MESI (0 rd data, 1 wr, 2 rd instr, 3 snoop inv, 4 snoop rd, 5 snoop wr, 6 snoop RWIM)
snoop_result  in  2  0=HIT, 1=HITM, 2/3=NOHIT
result  out  4  {hit_way[2:0], hit}
result_valid  out  1  one-cycle pulse for a completed LOOKUP
mesi_out  out  2  MESI of the addressed line after the op; 0=I, 1=S, 2=E, 3=M
victim_way  out  3  replacement way for the set of the last LOOKUP

Behaviour:
- Reset (async):
  - all lines MESI=I; all PLRU bits 0.
  - result=0, result_valid=0, mesi_out=0, victim_way=0.
  - Tags need not be cleared.
- Registered outputs, latency 1: inputs sampled at edge N, outputs valid after edge N, held until the next op.
- LOOKUP:
  - hit when some way has MESI!=I and stored tag==tag.
  - result={way,1'b1} on hit, else 4'b0000.
  - At most one matching valid way (controller invariant); if violated, the lowest way wins.
  - Lookup does not modify the LRU.
  - victim_way = lowest-numbered invalid way if any, else the PLRU-selected way.
- WRITE_TAG: stores tag in [index][way]; MESI unchanged.
- UPDATE_LRU:
  - Tree PLRU, bits b0 root, b1–b2 level 1, b3–b6 level 2.
  - Set the bits along the path so they point away from the way (way[2]=0 -> b0=1, etc.).
- UPDATE_MESI, transitions of [index][way]:
  - cmd 0/2:
    - if I: snoop HIT or HITM -> S; NOHIT -> E.
    - else unchanged.
  - cmd 1: -> M from any state.
  - cmd 3: S -> I; others unchanged.
  - cmd 4: E or M -> S; S, I unchanged.
  - cmd 5: unchanged.
  - cmd 6: -> I.
  - other cmd: unchanged.
  - mesi_out reports the new state.
- CLEAR: all lines -> I, all PLRU -> 0, completes in one cycle.
- op_valid=0 or an undefined op: no state change, result_valid=0.
- Same-cycle read-after-write: a LOOKUP one cycle after a WRITE/UPDATE sees the updated state.
- Reset asserted mid-operation aborts it; state returns to the reset values.

Test Plan:
- Reset -> LOOKUP idx 0, tag 12'h111 -> result=4'b0000, victim_way=0.
- Hit after fill:
  - Sequence on idx 0: WRITE_TAG tag 12'h111 way 2, UPDATE_LRU way 2, UPDATE_MESI cmd 1 snoop HIT (mesi_out=3).
  - Then LOOKUP idx 0 tag 12'h111 -> result=4'b0101.
- Set isolation:
  - After the hit scenario, LOOKUP idx 1 tag 12'h111 -> result=4'b0000.
  - LOOKUP idx 0 tag 12'h222 -> result=4'b0000.
- MESI sequence on a line:
  - cmd 0 + NOHIT: I -> E (mesi_out=2).
  - cmd 4: E -> S (mesi_out=1).
  - cmd 3: S -> I, after which LOOKUP misses.
  - Fresh line with cmd 0 + HITM -> S.
- PLRU:
  - Fill all 8 ways of idx 5 valid.
  - Touch ways 0..7 in order; LOOKUP reports victim_way=0.
  - Touch way 0; victim_way=4.
- CLEAR after filled lines -> every LOOKUP misses; async reset pulse mid-stream -> outputs 0 immediately.
